stream_mux_rr: RTL and testbench

- Parametrised N-to-1 stream multiplexer. It is the next generation of the team's fixed 4:1 combinational mux.
- Adds per-channel valid/ready handshakes and a registered output stage with 1-cycle latency.
- Selection mode is runtime-selectable: fixed select (legacy-compatible channel mapping) or round-robin arbitration.
- Sits between parallel producers and a single downstream consumer, e.g. the funnel in front of a shared processing unit.

---
 rtl/stream_mux_rr_if.sv | 28 ++
 rtl/stream_mux_rr.sv | 89 ++++++++
 tb/tb_stream_mux_rr.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/stream_mux_rr_if.sv
// rtl/stream_mux_rr_if.sv - handshake bundle between N producers, the mux and one consumer
interface stream_mux_rr_if #(
    parameter int N    = 4,
    parameter int W    = 2,
    parameter int SELW = 2
);
    logic                mode;
    logic [SELW-1:0]     sel;
    logic [N-1:0]        in_valid;
    logic [N*W-1:0]      in_data;
    logic [N-1:0]        in_ready;
    logic                out_valid;
    logic [W-1:0]        out_data;
    logic [SELW-1:0]     out_ch;
    logic                out_ready;

    // Mux side: consumes producer/consumer controls, drives readies and the output beat
    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );

    // Environment side: producers and consumer
    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-to-1 stream mux, fixed or round-robin select, registered output
module stream_mux_rr #(
    parameter int N       = 4,
    parameter int W       = 2,
    parameter int SELW    = 2,
    parameter bit REVERSE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    stream_mux_rr_if.slave   bus
);

    logic              out_valid_q;
    logic [W-1:0]      out_data_q;
    logic [SELW-1:0]   out_ch_q;
    logic [SELW-1:0]   rr_last;

    logic              load_en;
    logic              grant_valid;
    logic [SELW-1:0]   grant_idx;
    logic [W-1:0]      grant_data;
    logic [N-1:0]      ready_vec;
    logic              transfer;
    int                fixed_ch;
    int                cand;

    // Single-entry pipeline: accept a new beat whenever the register is empty or being drained
    assign load_en = ~out_valid_q | bus.out_ready;

    // Grant: fixed mode maps sel (possibly onto a non-existent channel), round-robin
    // searches cyclically starting just after the last granted channel
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        fixed_ch    = 0;
        cand        = 0;
        if (!bus.mode) begin
            fixed_ch = REVERSE ? (N - 1 - int'(bus.sel)) : int'(bus.sel);
            if (fixed_ch >= 0 && fixed_ch < N) begin
                grant_valid = 1'b1;
                grant_idx   = SELW'(fixed_ch);
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                cand = (int'(rr_last) + k) % N;
                if (!grant_valid && bus.in_valid[cand]) begin
                    grant_valid = 1'b1;
                    grant_idx   = SELW'(cand);
                end
            end
        end
    end

    // Only the granted channel sees ready, and never while reset is asserted
    always_comb begin
        ready_vec = '0;
        if (!rst && grant_valid) begin
            ready_vec[grant_idx] = load_en;
        end
    end

    assign grant_data   = bus.in_data[grant_idx*W +: W];
    assign transfer     = grant_valid & bus.in_valid[grant_idx] & ready_vec[grant_idx];
    assign bus.in_ready = ready_vec;

    // Output register and round-robin pointer; pointer only moves on round-robin grants
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_last     <= SELW'(N - 1);
        end else if (transfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= grant_data;
            out_ch_q    <= grant_idx;
            if (bus.mode) begin
                rr_last <= grant_idx;
            end
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - directed plus randomized bench for stream_mux_rr with a reference model
module tb_stream_mux_rr;
    localparam int N       = 4;
    localparam int W       = 2;
    localparam int SELW    = 2;
    localparam bit REVERSE = 1'b1;

    logic clk;
    logic rst;

    stream_mux_rr_if #(.N(N), .W(W), .SELW(SELW)) bus ();

    stream_mux_rr #(.N(N), .W(W), .SELW(SELW), .REVERSE(REVERSE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: held beat and the channel currently holding top priority
    logic          m_valid;
    logic [W-1:0]  m_data;
    int            m_ch;
    int            m_first;
    int            sb[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int model_grant();
        int idx;
        if (!bus.mode) begin
            idx = REVERSE ? (N - 1 - int'(bus.sel)) : int'(bus.sel);
            return (idx >= 0 && idx < N) ? idx : -1;
        end
        for (int k = 0; k < N; k++) begin
            idx = (m_first + k) % N;
            if (bus.in_valid[idx]) return idx;
        end
        return -1;
    endfunction

    // One clock: check combinational readies, track beats, advance the model, check outputs
    task automatic step();
        int            g;
        logic          can_load;
        logic [N-1:0]  exp_rdy;
        int            got_beat;
        #1;
        g        = model_grant();
        can_load = !m_valid || bus.out_ready;
        exp_rdy  = '0;
        if (!rst && g >= 0 && can_load) exp_rdy[g] = 1'b1;
        check_eq("in_ready", 32'(bus.in_ready), 32'(exp_rdy));

        if (rst) begin
            sb.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                got_beat = int'(bus.out_ch) * 256 + int'(bus.out_data);
                if (sb.size() > 0) check_eq("sb_beat", got_beat, sb.pop_front());
                else               check_eq("sb_unexpected_beat", 32'(bus.out_valid), 32'd0);
            end
            for (int c = 0; c < N; c++) begin
                if (bus.in_valid[c] && bus.in_ready[c]) sb.push_back(c * 256 + int'(bus.in_data[c*W +: W]));
            end
        end

        if (rst) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_ch    = 0;
            m_first = 0;
        end else if (g >= 0 && bus.in_valid[g] && can_load) begin
            m_valid = 1'b1;
            m_data  = bus.in_data[g*W +: W];
            m_ch    = g;
            if (bus.mode) m_first = (g + 1) % N;
        end else if (bus.out_ready) begin
            m_valid = 1'b0;
        end

        @(posedge clk);
        #1;
        check_eq("out_valid", 32'(bus.out_valid), 32'(m_valid));
        check_eq("out_data",  32'(bus.out_data),  32'(m_data));
        check_eq("out_ch",    32'(bus.out_ch),    32'(m_ch));
    endtask

    initial begin
        rst           = 1'b1;
        bus.mode      = 1'b1;
        bus.sel       = '0;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        m_valid = 1'b0; m_data = '0; m_ch = 0; m_first = 0;

        // Reset then idle
        step();
        step();
        check_eq("rst_out_valid", 32'(bus.out_valid), 0);
        check_eq("rst_out_data",  32'(bus.out_data),  0);
        check_eq("rst_out_ch",    32'(bus.out_ch),    0);
        rst = 1'b0;
        step();
        check_eq("idle_in_ready", 32'(bus.in_ready), 0);

        // Legacy reversed mapping
        bus.mode      = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 4'b1111;
        bus.in_data   = 8'b11_10_01_00;
        for (int k = 0; k < 4; k++) begin
            bus.sel = SELW'(k);
            step();
            check_eq("legacy_data", 32'(bus.out_data), 3 - k);
            check_eq("legacy_ch",   32'(bus.out_ch),   3 - k);
        end

        // Round-robin fairness, then a single active channel
        bus.mode = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check_eq("rr_ch", 32'(bus.out_ch), k % 4);
            check_eq("rr_valid", 32'(bus.out_valid), 1);
        end
        bus.in_valid = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("rr_only2", 32'(bus.out_ch), 2);
        end

        // Backpressure with a beat from ch1 holding 2'b10
        bus.in_valid = 4'b0010;
        bus.in_data  = 8'b11_10_10_00;
        step();
        bus.out_ready = 1'b0;
        bus.in_valid  = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            check_eq("bp_data",  32'(bus.out_data),  2);
            check_eq("bp_valid", 32'(bus.out_valid), 1);
            check_eq("bp_ready", 32'(bus.in_ready),  0);
        end
        bus.out_ready = 1'b1;
        step();
        check_eq("bp_release_ch", 32'(bus.out_ch), 2);

        // Fixed mode with the selected channel idle (sel=3 maps to ch0)
        bus.mode     = 1'b0;
        bus.sel      = 2'd3;
        bus.in_valid = 4'b1110;
        #1;
        check_eq("fixidle_ready", 32'(bus.in_ready), 32'b0001);
        step();
        check_eq("fixidle_valid", 32'(bus.out_valid), 0);

        // Reset mid-stream while ch3 is held
        bus.sel       = 2'd0;
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b0;
        step();
        check_eq("mid_hold_ch", 32'(bus.out_ch), 3);
        rst      = 1'b1;
        bus.mode = 1'b1;
        step();
        check_eq("mid_rst_valid", 32'(bus.out_valid), 0);
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check_eq("mid_first_ch", 32'(bus.out_ch), 0);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            rst           = ($urandom_range(0, 49) == 0);
            bus.mode      = 1'($urandom);
            bus.sel       = SELW'($urandom);
            bus.in_valid  = N'($urandom);
            bus.in_data   = (N*W)'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        rst = 1'b0;
        check_eq("sb_residual", sb.size(), 32'(m_valid));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
